// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
// sa_pkg : shared widths, step bounds and state encoding for sa_seq_ctrl
// rev 1.0
// ============================================================================
package sa_pkg;

  localparam int SIZE     = 10;
  localparam int N        = 4;
  localparam int FEED_LEN = 3*N - 2;
  localparam int STEP_W   = 4;
  localparam int LANE_W   = N*SIZE;
  localparam int RES_W    = 2*SIZE;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(FEED_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sa_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// sa_seq_ctrl_if : operand write port, control handshake and array edge drive
// rev 1.0
// ============================================================================
interface sa_seq_ctrl_if;
  import sa_pkg::*;

  logic              wr_en;
  logic              wr_sel;
  logic [1:0]        wr_row;
  logic [1:0]        wr_col;
  logic [SIZE-1:0]   wr_data;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              res_valid;
  logic              sa_clr;
  logic [LANE_W-1:0] sa_a;
  logic [LANE_W-1:0] sa_b;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start, abort,
    input  busy, done, res_valid, sa_clr, sa_a, sa_b
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start, abort,
    output busy, done, res_valid, sa_clr, sa_a, sa_b
  );

endinterface
`default_nettype wire

// File: rtl/sa_mat_buf.sv
`default_nettype none
// ============================================================================
// sa_mat_buf : 4x4 operand register file, one write port, four skewed reads
// rev 1.0
// ============================================================================
module sa_mat_buf
  import sa_pkg::*;
#(
  parameter bit TRANSPOSE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [1:0]        wr_row,
  input  logic [1:0]        wr_col,
  input  logic [SIZE-1:0]   wr_data,
  input  logic [STEP_W-1:0] step,
  output logic [LANE_W-1:0] lanes
);

  logic [N-1:0][N-1:0][SIZE-1:0] r_mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem <= '0;
    end else if (wr_en) begin
      r_mem[wr_row][wr_col] <= wr_data;
    end
  end

  // Lane l carries element index k = step - l; outside 0..N-1 the lane idles at zero.
  for (genvar l = 0; l < N; l++) begin : g_lane
    logic [STEP_W-1:0] w_k;
    logic [1:0]        w_ki;
    logic              w_in_win;

    assign w_k      = step - STEP_W'(l);
    assign w_ki     = w_k[1:0];
    assign w_in_win = (step >= STEP_W'(l)) && (w_k < STEP_W'(N));

    if (TRANSPOSE) begin : g_col
      assign lanes[l*SIZE +: SIZE] = w_in_win ? r_mem[w_ki][l] : '0;
    end else begin : g_row
      assign lanes[l*SIZE +: SIZE] = w_in_win ? r_mem[l][w_ki] : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sa_seq_ctrl.sv
`default_nettype none
// ============================================================================
// sa_seq_ctrl : loads A/B, clears the systolic array and feeds skewed operands
// rev 1.0
// ============================================================================
module sa_seq_ctrl
  import sa_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  sa_seq_ctrl_if.slave bus
);

  state_t            r_state, w_state_nx;
  logic [STEP_W-1:0] r_step, w_step_nx;
  logic              r_busy, r_done, r_res_valid, r_sa_clr;
  logic              w_busy_nx, w_done_nx, w_res_valid_nx, w_sa_clr_nx, w_feed_nx;
  logic [LANE_W-1:0] r_sa_a, r_sa_b, w_a_lanes, w_b_lanes;
  logic              w_wr_ok;

  assign w_wr_ok = bus.wr_en && (r_state == IDLE);

  // Buffers are read with the next step so the lane registers load in step.
  sa_mat_buf #(.TRANSPOSE(1'b0)) u_buf_a (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_wr_ok && !bus.wr_sel),
    .wr_row  (bus.wr_row),
    .wr_col  (bus.wr_col),
    .wr_data (bus.wr_data),
    .step    (w_step_nx),
    .lanes   (w_a_lanes)
  );

  sa_mat_buf #(.TRANSPOSE(1'b1)) u_buf_b (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_wr_ok && bus.wr_sel),
    .wr_row  (bus.wr_row),
    .wr_col  (bus.wr_col),
    .wr_data (bus.wr_data),
    .step    (w_step_nx),
    .lanes   (w_b_lanes)
  );

  always_comb begin
    w_state_nx     = r_state;
    w_step_nx      = '0;
    w_busy_nx      = 1'b0;
    w_done_nx      = 1'b0;
    w_sa_clr_nx    = 1'b0;
    w_feed_nx      = 1'b0;
    w_res_valid_nx = r_res_valid;
    case (r_state)
      IDLE: begin
        if (w_wr_ok) w_res_valid_nx = 1'b0;
        if (bus.start) begin
          w_state_nx     = CLEAR;
          w_sa_clr_nx    = 1'b1;
          w_busy_nx      = 1'b1;
          w_res_valid_nx = 1'b0;
        end
      end
      CLEAR: begin
        if (bus.abort) begin
          w_state_nx = IDLE;
        end else begin
          w_state_nx = FEED;
          w_busy_nx  = 1'b1;
          w_feed_nx  = 1'b1;
        end
      end
      FEED: begin
        if (bus.abort) begin
          w_state_nx = IDLE;
        end else if (r_step == LAST_STEP) begin
          w_state_nx     = IDLE;
          w_done_nx      = 1'b1;
          w_res_valid_nx = 1'b1;
        end else begin
          w_step_nx = r_step + STEP_W'(1);
          w_busy_nx = 1'b1;
          w_feed_nx = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_res_valid <= 1'b0;
      r_sa_clr    <= 1'b0;
      r_sa_a      <= '0;
      r_sa_b      <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_step      <= w_step_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_res_valid <= w_res_valid_nx;
      r_sa_clr    <= w_sa_clr_nx;
      r_sa_a      <= w_feed_nx ? w_a_lanes : '0;
      r_sa_b      <= w_feed_nx ? w_b_lanes : '0;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.res_valid = r_res_valid;
  assign bus.sa_clr    = r_sa_clr;
  assign bus.sa_a      = r_sa_a;
  assign bus.sa_b      = r_sa_b;

endmodule
`default_nettype wire

// File: tb/tb_sa_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sa_seq_ctrl : sequencer driving a behavioural 4x4 output-stationary array
// rev 1.0
// ============================================================================
module tb_sa_seq_ctrl;
  import sa_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sa_seq_ctrl_if bus();

  sa_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int ma [N][N];
  int mb [N][N];

  // Output-stationary array: a moves right, b moves down, each PE accumulates a*b.
  logic [RES_W-1:0] arr_c [N][N];
  logic [SIZE-1:0]  arr_a [N][N];
  logic [SIZE-1:0]  arr_b [N][N];
  logic [SIZE-1:0]  ai, bi;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) ai = bus.sa_a[i*SIZE +: SIZE];
        else        ai = arr_a[i][j-1];
        if (i == 0) bi = bus.sa_b[j*SIZE +: SIZE];
        else        bi = arr_b[i-1][j];
        if (bus.sa_clr) begin
          arr_c[i][j] <= '0;
          arr_a[i][j] <= '0;
          arr_b[i][j] <= '0;
        end else begin
          arr_c[i][j] <= arr_c[i][j] + RES_W'(ai) * RES_W'(bi);
          arr_a[i][j] <= ai;
          arr_b[i][j] <= bi;
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LANE_W-1:0] exp_lanes(input bit sel_b, input int t);
    logic [LANE_W-1:0] v = '0;
    for (int l = 0; l < N; l++) begin
      int k = t - l;
      if (k >= 0 && k < N) v[l*SIZE +: SIZE] = SIZE'(sel_b ? mb[k][l] : ma[l][k]);
    end
    return v;
  endfunction

  function automatic logic [RES_W-1:0] ref_c(input int i, input int j);
    logic [RES_W-1:0] s = '0;
    for (int k = 0; k < N; k++) s += RES_W'(ma[i][k] * mb[k][j]);
    return s;
  endfunction

  task automatic write_elem(input bit sel, input int row, input int col, input int val);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_row  = 2'(row);
    bus.wr_col  = 2'(col);
    bus.wr_data = SIZE'(val);
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        write_elem(1'b0, i, j, ma[i][j]);
        write_elem(1'b1, i, j, mb[i][j]);
      end
  endtask

  // cyc counts edges since start was sampled; FEED step t is observed at cyc = t+2.
  task automatic run_mult(input string tag, input bit chk_lanes, input int restart_at,
                          input int write_at, input int abort_at);
    int done_cnt = 0;
    int done_cyc = -1;
    int clr_cnt  = 0;
    int wv;
    bit aborted  = (abort_at > 0);
    wv = (ma[1][2] + 1 + int'($urandom_range(0, 500))) % 1024;
    bus.wr_sel  = 1'b0;
    bus.wr_row  = 2'd1;
    bus.wr_col  = 2'd2;
    bus.wr_data = SIZE'(wv);
    @(negedge clk);
    bus.start = 1'b1;
    if (write_at == 0) begin
      bus.wr_en = 1'b1;
      ma[1][2]  = wv;
    end
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (bus.sa_clr) clr_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (chk_lanes && cyc >= 2 && cyc <= 11) begin
        check_val($sformatf("%s:sa_a_t%0d", tag, cyc-2), bus.sa_a, exp_lanes(1'b0, cyc-2));
        check_val($sformatf("%s:sa_b_t%0d", tag, cyc-2), bus.sa_b, exp_lanes(1'b1, cyc-2));
      end
      if (aborted && cyc == abort_at + 1) begin
        check_val({tag, ":abort_busy"}, bus.busy, 0);
        check_val({tag, ":abort_sa_a"}, bus.sa_a, 0);
        check_val({tag, ":abort_sa_b"}, bus.sa_b, 0);
        check_val({tag, ":abort_res_valid"}, bus.res_valid, 0);
      end
      bus.start = (cyc == restart_at);
      bus.abort = (cyc == abort_at);
      bus.wr_en = (cyc == write_at);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.wr_en = 1'b0;
    check_val({tag, ":done_count"}, done_cnt, aborted ? 0 : 1);
    check_val({tag, ":clr_cycles"}, clr_cnt, 1);
    check_val({tag, ":busy_after"}, bus.busy, 0);
    if (!aborted) begin
      check_val({tag, ":latency"}, done_cyc, 12);
      check_val({tag, ":res_valid"}, bus.res_valid, 1);
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          check_val($sformatf("%s:c%0d", tag, 4*i+j+1), arr_c[i][j], ref_c(i, j));
    end
  endtask

  task automatic randomize_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = int'($urandom_range(0, 1023));
        mb[i][j] = int'($urandom_range(0, 1023));
      end
  endtask

  initial begin
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_row  = '0;
    bus.wr_col  = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    #12;
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_res_valid", bus.res_valid, 0);
    check_val("rst_sa_clr", bus.sa_clr, 0);
    check_val("rst_sa_a", bus.sa_a, 0);
    check_val("rst_sa_b", bus.sa_b, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = 4*i + j + 1;
      end
    load_all();
    run_mult("ident", 1'b0, -1, -1, -1);

    // An accepted write invalidates the held product.
    write_elem(1'b0, 0, 0, ma[0][0]);
    #1 check_val("wr_clears_res_valid", bus.res_valid, 0);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (j == i) ? 1 : ((j == (i + 1) % N) ? 2 : 0);
        mb[i][j] = ma[i][j];
      end
    load_all();
    run_mult("general", 1'b1, -1, -1, -1);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 1023;
        mb[i][j] = 1023;
      end
    load_all();
    run_mult("overflow", 1'b0, -1, -1, -1);

    randomize_mats();
    load_all();
    run_mult("b2b_ignored", 1'b1, 6, 8, -1);
    run_mult("b2b_rerun", 1'b0, -1, -1, -1);

    randomize_mats();
    load_all();
    run_mult("wr_with_start", 1'b1, -1, 0, -1);

    randomize_mats();
    load_all();
    run_mult("abort", 1'b0, -1, -1, 7);
    run_mult("after_abort", 1'b1, -1, -1, -1);

    // Asynchronous reset at FEED t=3, checked before the next rising edge.
    randomize_mats();
    load_all();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check_val("pre_reset_busy", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    check_val("async_busy", bus.busy, 0);
    check_val("async_sa_a", bus.sa_a, 0);
    check_val("async_sa_b", bus.sa_b, 0);
    check_val("async_done", bus.done, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
    run_mult("post_reset", 1'b1, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sa_seq_ctrl.md
Name: sa_seq_ctrl

Overview:
Sequencer for the 4x4 output-stationary systolic multiply array. It holds operand matrices A and B (4x4, SIZE-bit elements) loaded over a simple write port. On start, it clears the array and streams skewed row/column operands into its a1..a4 / b1..b4 edges. It then signals completion, leaving C = A*B on the array's c1..c16 outputs.

Parameters:
SIZE, 10, element width; must match the array's element width; array results are 2*SIZE bits
N, 4, array dimension; fixed at 4, exposed only for package consistency

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high; forces IDLE
wr_en  input  1  buffer write strobe
wr_sel  input  1  0 = matrix A, 1 = matrix B
wr_row  input  2  element row index
wr_col  input  2  element column index
wr_data  input  SIZE  element value (unsigned)
start  input  1  launch multiply; sampled in IDLE only
abort  input  1  cancel an in-flight multiply
busy  output  1  high in CLEAR and FEED
done  output  1  one-cycle pulse at completion
res_valid  output  1  high while array c1..c16 hold a valid product
sa_clr  output  1  drives the array's synchronous reset input
sa_a  output  4*SIZE  lane i (bits i*SIZE +: SIZE) drives array a(i+1)
sa_b  output  4*SIZE  lane j drives array b(j+1)

Behaviour:
- Reset values: busy=0, done=0, res_valid=0, sa_clr=0, sa_a=0, sa_b=0, state=IDLE, step counter=0, both buffers all zero.
- All outputs are registered.
- Writes: accepted only in IDLE, stored at the clock edge, and ignored while busy. Any accepted write clears res_valid.
- States: IDLE -> CLEAR -> FEED -> IDLE.
- IDLE: sa_a=sa_b=0. start=1 -> CLEAR. If start and wr_en are asserted in the same cycle, the write commits and the multiply uses the new value.
- CLEAR: lasts exactly 1 cycle. sa_clr=1, sa_a=sa_b=0, busy=1, res_valid=0. Goes to FEED with step t=0.
- FEED: lasts 10 cycles (t=0..9, 3N-2), with busy=1 and sa_clr=0. During cycle t:
  - lane i of sa_a = A[i][t-i] when 0<=t-i<=3, else 0
  - lane j of sa_b = B[t-j][j] when 0<=t-j<=3, else 0
- Completion: after t=9 the state returns to IDLE. In the first IDLE cycle, done=1 for one cycle, busy=0 and res_valid=1. The array's c(4i+j+1) then equals C[i][j].
- Latency: from start sampled to done is 12 cycles (1 IDLE edge + 1 CLEAR + 10 FEED).
- Holding results: after FEED, sa_a/sa_b stay 0, so the array keeps accumulating zeros and c1..c16 stay stable. res_valid stays high until the next start or an accepted write.
- Arithmetic: unsigned. Each C element is the sum of 4 products, computed modulo 2^(2*SIZE); overflow wraps silently.
- Ignored inputs: start while busy is ignored (no queueing). abort in IDLE is ignored.
- abort in CLEAR or FEED: at the next edge go to IDLE with sa_a=sa_b=0, busy=0, no done pulse and res_valid=0. Buffers are unchanged.
- Async reset mid-operation: immediate return to reset values. Buffers are cleared and no done is produced. The array contents are undefined until the next CLEAR.

Decomposition:
- Package sa_pkg holds:
  - SIZE and N
  - FEED_LEN = 3*N-2
  - the state enum {IDLE, CLEAR, FEED}
  - the lane-slice helper constants
- One sub-module, sa_mat_buf: 4x4 x SIZE register file with one write port and four parallel skew-indexed read ports. It is instantiated twice, once for A and once for B.
- The FSM, step counter and output registers live in sa_seq_ctrl.

Test Plan:
- Identity product: load A=identity, B rows [1 2 3 4][5 6 7 8][9 10 11 12][13 14 15 16]; start -> done exactly 12 cycles after start, c1..c16 = 1..16, res_valid=1.
- General product: A=B=[[1,2,0,0],[0,1,2,0],[0,0,1,2],[2,0,0,1]] -> C rows [1,4,4,0],[0,1,4,4],[4,0,1,4],[4,4,0,1]. Also check sa_a/sa_b lane values per step t=0..9 against the skew rule.
- Overflow wrap: all elements 1023 -> every c = 4*1023^2 mod 2^20 = 1040388.
- Back-to-back: second start pulsed during FEED is ignored (single done). A write during busy is ignored; a fresh start then reproduces the same C. Check that sa_clr goes high for exactly one cycle each run.
- Abort at FEED t=5 -> next cycle busy=0, sa_a=sa_b=0, no done, res_valid=0. A following start yields the correct C.
- Async reset asserted at FEED t=3, released 2 cycles later -> outputs drop to 0 without waiting for a clock edge. Buffers read zero, so a subsequent start gives all c=0 and done.
